// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit datapath.
// Owns the PC, fetches 16-bit instructions over req/ack, and steers the
// register file, ALU and call stack. All outputs are registered.
module instr_sequencer #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned RF_AW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [15:0]      imem_data,
  output logic [RF_AW-1:0] rf_addr_a,
  output logic [RF_AW-1:0] rf_addr_b,
  output logic             rf_we,
  output logic [7:0]       alu_opcode,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [PC_W-1:0]  stk_wdata,
  input  logic [PC_W-1:0]  stk_rdata,
  input  logic             stk_full,
  input  logic             stk_empty,
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic             fault
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StWb, StRetw, StHalt, StFault
  } state_e;

  typedef enum logic [2:0] {ClsNop, ClsAlu, ClsHalt, ClsCall, ClsRet} op_class_e;

  function automatic op_class_e classify(input logic [7:0] op);
    op_class_e cls;
    if (op <= 8'h12 || op == 8'h14) cls = ClsAlu;
    else if (op == 8'h13)           cls = ClsHalt;
    else if (op == 8'h15)           cls = ClsCall;
    else if (op == 8'h16)           cls = ClsRet;
    else                            cls = ClsNop;
    return cls;
  endfunction

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [15:0]      ir_q, ir_d;
  logic             req_q, req_d;
  logic [RF_AW-1:0] addr_a_q, addr_a_d;
  logic [RF_AW-1:0] addr_b_q, addr_b_d;
  logic             we_q, we_d;
  logic [7:0]       op_q, op_d;
  logic             push_q, push_d;
  logic             pop_q, pop_d;
  logic [PC_W-1:0]  wdata_q, wdata_d;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;

  op_class_e fetch_cls, ir_cls;
  logic [PC_W-1:0] pc_inc;

  assign fetch_cls = classify(imem_data[15:8]);
  assign ir_cls    = classify(ir_q[15:8]);
  assign pc_inc    = pc_q + PC_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic. Stack strobes are issued at the fetch edge, so DECODE
  // dispatches CALL/RET on whether that strobe was actually granted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StFetch;
      StFetch:  if (imem_ack) state_d = StDecode;
      StDecode: begin
        case (ir_cls)
          ClsAlu:  state_d = StExec;
          ClsHalt: state_d = StHalt;
          ClsCall: state_d = push_q ? StFetch : StFault;
          ClsRet:  state_d = pop_q ? StRetw : StFault;
          default: state_d = StFetch;
        endcase
      end
      StExec:   state_d = StWb;
      StWb:     state_d = StFetch;
      StRetw:   state_d = StFetch;
      StHalt:   if (start) state_d = StFetch;
      StFault:  state_d = StFault;
      default:  state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs, PC and instruction register.
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    op_d     = op_q;
    wdata_d  = wdata_q;
    push_d   = 1'b0;
    pop_d    = 1'b0;
    req_d    = (state_d == StFetch);
    we_d     = (state_d == StWb);
    halted_d = (state_d == StHalt);
    fault_d  = (state_d == StFault);
    unique case (state_q)
      StIdle: if (start) pc_d = '0;
      StFetch: begin
        if (imem_ack) begin
          // Decode fields are loaded straight from the bus so they are
          // already valid while the FSM sits in DECODE.
          ir_d     = imem_data;
          addr_a_d = RF_AW'(imem_data[7:5]);
          addr_b_d = RF_AW'(imem_data[4:2]);
          op_d     = imem_data[15:8];
          if (fetch_cls == ClsCall && !stk_full) begin
            push_d  = 1'b1;
            wdata_d = pc_inc;
          end
          if (fetch_cls == ClsRet && !stk_empty) pop_d = 1'b1;
        end
      end
      StDecode: begin
        case (ir_cls)
          ClsNop, ClsHalt: pc_d = pc_inc;
          ClsCall:         if (push_q) pc_d = PC_W'(ir_q[7:0]);
          default:         pc_d = pc_q;
        endcase
      end
      StWb:    pc_d = pc_inc;
      StRetw:  pc_d = stk_rdata;
      default: pc_d = pc_q;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      ir_q     <= '0;
      req_q    <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      we_q     <= 1'b0;
      op_q     <= 8'hFF;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      wdata_q  <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      req_q    <= req_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      we_q     <= we_d;
      op_q     <= op_d;
      push_q   <= push_d;
      pop_q    <= pop_d;
      wdata_q  <= wdata_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign rf_addr_a  = addr_a_q;
  assign rf_addr_b  = addr_b_q;
  assign rf_we      = we_q;
  assign alu_opcode = op_q;
  assign stk_push   = push_q;
  assign stk_pop    = pop_q;
  assign stk_wdata  = wdata_q;
  assign pc         = pc_q;
  assign halted     = halted_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios followed by a
// random program checked against an instruction-level reference model.
module tb_instr_sequencer;

  localparam int PC_W      = 8;
  localparam int RF_AW     = 3;
  localparam int STK_DEPTH = 4;

  localparam int C_NOP = 0, C_ALU = 1, C_HALT = 2, C_CALL = 3, C_RET = 4;
  localparam int O_FETCH = 0, O_HALT = 1, O_FAULT = 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ack;
  logic [15:0]      imem_data;
  logic [RF_AW-1:0] rf_addr_a;
  logic [RF_AW-1:0] rf_addr_b;
  logic             rf_we;
  logic [7:0]       alu_opcode;
  logic             stk_push;
  logic             stk_pop;
  logic [PC_W-1:0]  stk_wdata;
  logic [PC_W-1:0]  stk_rdata;
  logic             stk_full;
  logic             stk_empty;
  logic [PC_W-1:0]  pc;
  logic             halted;
  logic             fault;

  instr_sequencer #(.PC_W(PC_W), .RF_AW(RF_AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .rf_addr_a  (rf_addr_a),
    .rf_addr_b  (rf_addr_b),
    .rf_we      (rf_we),
    .alu_opcode (alu_opcode),
    .stk_push   (stk_push),
    .stk_pop    (stk_pop),
    .stk_wdata  (stk_wdata),
    .stk_rdata  (stk_rdata),
    .stk_full   (stk_full),
    .stk_empty  (stk_empty),
    .pc         (pc),
    .halted     (halted),
    .fault      (fault)
  );

  int tests = 0;
  int failures = 0;
  int ack_delay = 0;

  logic [15:0] imem [256];
  logic [7:0]  dut_stk [$];   // stack contents as seen by the DUT
  logic [7:0]  m_stk [$];     // reference model stack
  logic [7:0]  m_pc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory responder: acks after ack_delay waiting cycles.
  initial begin
    int wcnt;
    wcnt = 0;
    imem_ack = 1'b0;
    imem_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req) begin
        if (wcnt >= ack_delay) begin
          imem_ack = 1'b1;
          imem_data = imem[imem_addr];
          wcnt = 0;
        end else begin
          imem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Stack device: push/pop take effect mid-cycle, popped data held afterwards.
  initial begin
    stk_rdata = '0;
    stk_full = 1'b0;
    stk_empty = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dut_stk.delete();
      end else begin
        if (stk_push && dut_stk.size() < STK_DEPTH) dut_stk.push_back(stk_wdata);
        if (stk_pop && dut_stk.size() > 0) stk_rdata = dut_stk.pop_back();
      end
      stk_full = (dut_stk.size() >= STK_DEPTH);
      stk_empty = (dut_stk.size() == 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int classify(input logic [7:0] op);
    if (op <= 8'h12 || op == 8'h14) return C_ALU;
    if (op == 8'h13) return C_HALT;
    if (op == 8'h15) return C_CALL;
    if (op == 8'h16) return C_RET;
    return C_NOP;
  endfunction

  function automatic logic [15:0] gen_instr();
    logic [7:0] op;
    int r;
    r = $urandom_range(0, 9);
    if (r <= 4) begin
      op = 8'($urandom_range(0, 8'h13));
      if (op == 8'h13) op = 8'h14;
    end else if (r == 5) op = 8'($urandom_range(8'h17, 8'hFF));
    else if (r <= 7)     op = 8'h15;
    else if (r == 8)     op = 8'h16;
    else                 op = ($urandom_range(0, 1) == 1) ? 8'h13 : 8'h16;
    return {op, 8'($urandom)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_pc", pc, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_alu_opcode", alu_opcode, 32'hFF);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_push_pop", {stk_push, stk_pop}, 0);
    chk("rst_stk_wdata", stk_wdata, 0);
    chk("rst_rf_addr", {rf_addr_a, rf_addr_b}, 0);
    chk("rst_halted_fault", {halted, fault}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 8'h00;
    m_stk.delete();
    ack_delay = 0;
    tick();
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs one instruction from its first FETCH cycle up to the next FETCH,
  // HALT or FAULT, and checks it against the instruction-level model.
  task automatic exec_one(input int delay, output int outcome);
    logic [15:0] ins;
    int exp_lat, exp_out, exp_we, exp_push, exp_pop;
    logic [7:0] exp_next, exp_wd;
    int cyc, fcyc, we, push, pop, obs_out;
    bit seen_drop, addr_moved, excl_bad, done;
    logic [7:0] wd, wop;
    logic [2:0] wa, wb;
    ack_delay = delay;
    ins = imem[m_pc];
    exp_lat = 2; exp_out = O_FETCH; exp_we = 0; exp_push = 0; exp_pop = 0;
    exp_next = m_pc + 8'd1;
    exp_wd = 8'd0;
    case (classify(ins[15:8]))
      C_ALU: begin exp_lat = 4; exp_we = 1; end
      C_HALT: exp_out = O_HALT;
      C_CALL: begin
        if (m_stk.size() < STK_DEPTH) begin
          exp_push = 1; exp_wd = m_pc + 8'd1; exp_next = ins[7:0];
        end else exp_out = O_FAULT;
      end
      C_RET: begin
        if (m_stk.size() > 0) begin
          exp_lat = 3; exp_pop = 1; exp_next = m_stk[$];
        end else exp_out = O_FAULT;
      end
      default: ;
    endcase
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, m_pc);
    chk("pc_out", pc, m_pc);
    cyc = 0; fcyc = 0; we = 0; push = 0; pop = 0;
    seen_drop = 0; addr_moved = 0; excl_bad = 0; done = 0;
    wd = 0; wop = 0; wa = 0; wb = 0;
    while (!done) begin
      if (!seen_drop) begin
        fcyc++;
        if (imem_addr !== m_pc) addr_moved = 1;
      end
      if (rf_we) begin we++; wa = rf_addr_a; wb = rf_addr_b; wop = alu_opcode; end
      if (stk_push) begin push++; wd = stk_wdata; end
      if (stk_pop) pop++;
      if (int'(rf_we) + int'(stk_push) + int'(stk_pop) > 1) excl_bad = 1;
      tick();
      cyc++;
      if (!imem_req) seen_drop = 1;
      if ((seen_drop && (imem_req || halted || fault)) || cyc >= 60) done = 1;
    end
    obs_out = fault ? O_FAULT : (halted ? O_HALT : O_FETCH);
    chk("latency", cyc, exp_lat + delay);
    chk("fetch_cycles", fcyc, delay + 1);
    chk("addr_stable", addr_moved, 0);
    chk("outcome", obs_out, exp_out);
    chk("rf_we_pulses", we, exp_we);
    chk("push_pulses", push, exp_push);
    chk("pop_pulses", pop, exp_pop);
    chk("strobe_excl", excl_bad, 0);
    if (exp_we == 1) begin
      chk("wb_rf_addr_a", wa, ins[7:5]);
      chk("wb_rf_addr_b", wb, ins[4:2]);
      chk("wb_alu_opcode", wop, ins[15:8]);
    end
    if (exp_push == 1) chk("push_wdata", wd, exp_wd);
    if (exp_out == O_FETCH) chk("next_fetch_addr", imem_addr, exp_next);
    if (exp_push == 1) m_stk.push_back(exp_wd);
    if (exp_pop == 1) void'(m_stk.pop_back());
    m_pc = exp_next;
    outcome = exp_out;
  endtask

  task automatic resume_after_halt();
    bit bad;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!halted || imem_req) bad = 1;
      tick();
    end
    chk("halt_idle", bad, 0);
    start_run();
    chk("resume_halted", halted, 0);
    chk("resume_req", imem_req, 1);
    chk("resume_addr", imem_addr, m_pc);
  endtask

  task automatic hold_fault_then_reset();
    bit bad;
    bad = 0;
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (!fault || imem_req || stk_pop || stk_push || rf_we) bad = 1;
      tick();
    end
    start = 1'b0;
    chk("fault_sticky", bad, 0);
    do_reset();
    chk("fault_cleared", fault, 0);
  endtask

  initial begin
    int o;
    bit bad;
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 16'hFF00;
    imem[8'h00] = 16'h0044;   // ADD rd=2 rs=1
    imem[8'h01] = 16'h0AE8;   // ALU rd=7 rs=2
    imem[8'h05] = 16'h1540;   // CALL 0x40
    imem[8'h40] = 16'h1600;   // RET
    imem[8'h10] = 16'h1300;   // HALT
    imem[8'h11] = 16'h15FF;   // CALL 0xFF

    do_reset();
    chk_reset_vals();

    // ALU op with zero-wait ack, then one with a delayed ack.
    start_run();
    exec_one(0, o);
    exec_one(3, o);

    // NOPs up to the CALL at 0x05, then the RET at 0x40.
    for (int i = 0; i < 3; i++) exec_one($urandom_range(0, 2), o);
    exec_one(0, o);
    chk("call_target", m_pc, 8'h40);
    exec_one(1, o);
    chk("ret_target", m_pc, 8'h06);

    // NOPs up to HALT at 0x10, resume at 0x11, CALL to 0xFF, NOP wraps.
    for (int i = 0; i < 10; i++) exec_one($urandom_range(0, 2), o);
    exec_one(0, o);
    chk("halt_outcome", o, O_HALT);
    resume_after_halt();
    exec_one(0, o);
    exec_one(2, o);
    chk("wrap_pc", m_pc, 8'h00);

    // RET on an empty stack faults; start is ignored until reset.
    do_reset();
    imem[8'h00] = 16'h1600;
    start_run();
    exec_one(0, o);
    chk("ret_empty_outcome", o, O_FAULT);
    hold_fault_then_reset();
    chk_reset_vals();
    imem[8'h00] = 16'h0044;

    // Asynchronous reset while a fetch is waiting for ack.
    start_run();
    exec_one(0, o);
    ack_delay = 10;
    tick();
    tick();
    chk("pre_reset_req", imem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("async_req_drop", imem_req, 0);
    chk("async_pc", pc, 0);
    chk("async_alu_opcode", alu_opcode, 32'hFF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 8'h00;
    m_stk.delete();
    ack_delay = 0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (imem_req) bad = 1;
    end
    chk("idle_after_reset", bad, 0);

    // Random programs against the reference model.
    for (int i = 0; i < 256; i++) imem[i] = gen_instr();
    start_run();
    for (int n = 0; n < 200; n++) begin
      exec_one($urandom_range(0, 3), o);
      if (o == O_HALT) begin
        resume_after_halt();
      end else if (o == O_FAULT) begin
        hold_fault_then_reset();
        start_run();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
